// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbitrated multiplexer with a one-entry registered
// output stage. Each input channel and the output use a valid/ready handshake.
// An internal arbiter picks the channel: fixed priority (lowest index wins)
// or round-robin starting at a pointer. The pointer moves past the last
// channel that was granted.
module arb_mux_n #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int RR_MODE  = 1,
   parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [CW-1:0]             out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_data;
   logic [CW-1:0]       r_out_chan;
   logic [CW-1:0]       r_ptr;

   logic                w_can_load;
   logic                w_any;
   logic                w_xfer;
   logic [CHANNELS-1:0] w_upper;
   logic [CHANNELS-1:0] w_req;
   logic [CHANNELS-1:0] w_grant;
   logic [CW-1:0]       w_gnt_idx;
   logic [CW-1:0]       w_ptr_next;
   logic [WIDTH-1:0]    w_sel_data;

   // The output register can take a new word when it is empty, or when it is
   // being drained in this same cycle. This gives back-to-back throughput.
   assign w_can_load = !r_out_valid || out_ready;
   assign w_any      = |in_valid;
   assign w_xfer     = w_any && w_can_load;

   // Requests at or above the round-robin pointer are tried first
   always_comb begin
      // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
      w_upper = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_upper[i] = in_valid[i] && (CW'(i) >= r_ptr);
      end
   end

   // Round-robin wraps to the full request set when nothing lies above the pointer
   assign w_req = ((RR_MODE != 0) && (|w_upper)) ? w_upper : in_valid;

   // Lowest set bit of w_req; the downward scan lets lower indices overwrite higher ones
   always_comb begin
      w_gnt_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_gnt_idx = CW'(i);
         end
      end
   end

   // One-hot grant and data select, driven from the winning index
   always_comb begin
      w_grant    = '0;
      w_sel_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_gnt_idx == CW'(i)) begin
            w_grant[i] = w_any;
            w_sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // in_ready is forced low while reset is asserted, even though the register is empty
   assign in_ready = w_grant & {CHANNELS{w_can_load && reset_n}};

   assign w_ptr_next = (w_gnt_idx == CW'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;

   // Output register and round-robin pointer; on reset, any word held here is discarded
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: all state uses non-blocking assignments, so every register samples the values from before the edge.
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_ptr       <= '0;
      end else begin
         if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_gnt_idx;
            if (RR_MODE != 0) begin
               r_ptr <= w_ptr_next;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: runs one round-robin instance and one fixed-priority instance
// side by side. A transaction-level model predicts in_ready, out_valid,
// out_data and out_chan for each cycle.
module tb_arb_mux_n;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int CWB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   // Stimulus per instance: index 0 = round-robin, 1 = fixed priority
   logic [W-1:0] s_word   [2][N];
   logic [N-1:0] s_valid  [2];
   logic         s_oready [2];

   logic [N*W-1:0] rr_in_data, fp_in_data;
   logic [N-1:0]   rr_in_ready, fp_in_ready;
   logic [W-1:0]   rr_out_data, fp_out_data;
   logic [CWB-1:0] rr_out_chan, fp_out_chan;
   logic           rr_out_valid, fp_out_valid;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         rr_in_data[i*W +: W] = s_word[0][i];
         fp_in_data[i*W +: W] = s_word[1][i];
      end
   end

   arb_mux_n #(.WIDTH(W), .CHANNELS(N), .RR_MODE(1)) u_rr (
      .clk(clk), .reset_n(reset_n), .in_data(rr_in_data), .in_valid(s_valid[0]),
      .in_ready(rr_in_ready), .out_data(rr_out_data), .out_chan(rr_out_chan),
      .out_valid(rr_out_valid), .out_ready(s_oready[0]));

   arb_mux_n #(.WIDTH(W), .CHANNELS(N), .RR_MODE(0)) u_fp (
      .clk(clk), .reset_n(reset_n), .in_data(fp_in_data), .in_valid(s_valid[1]),
      .in_ready(fp_in_ready), .out_data(fp_out_data), .out_chan(fp_out_chan),
      .out_valid(fp_out_valid), .out_ready(s_oready[1]));

   // Reference model state
   logic         m_valid [2];
   logic [W-1:0] m_data  [2];
   int           m_chan  [2];
   int           m_ptr   [2];

   logic [N-1:0] last_acc   [2];
   logic [N-1:0] last_ready [2];
   int           last_g     [2];
   string        nm [2] = '{"rr", "fp"};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Which channel wins: a scan starting at ptr (wrapping) for round-robin, from 0 for fixed
   function automatic int exp_grant(input logic [N-1:0] v, input int ptr, input bit rr);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = rr ? (ptr + k) % N : k;
         if (v[idx[CWB-1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_valid[d]  = 1'b0;
         m_data[d]   = '0;
         m_chan[d]   = 0;
         m_ptr[d]    = 0;
         last_acc[d] = '0;
      end
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after
   task automatic step();
      int g;
      #1;
      last_ready[0] = rr_in_ready;
      last_ready[1] = fp_in_ready;
      for (int d = 0; d < 2; d++) begin
         g           = exp_grant(s_valid[d], m_ptr[d], d == 0);
         last_g[d]   = g;
         last_acc[d] = '0;
         if (g >= 0 && (!m_valid[d] || s_oready[d])) last_acc[d][g[CWB-1:0]] = 1'b1;
         check({nm[d], ".in_ready"}, 64'(last_ready[d]), 64'(last_acc[d]));
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (last_acc[d] != '0) begin
            m_valid[d] = 1'b1;
            m_data[d]  = s_word[d][last_g[d]];
            m_chan[d]  = last_g[d];
            if (d == 0) m_ptr[d] = (last_g[d] + 1) % N;
         end else if (s_oready[d]) begin
            m_valid[d] = 1'b0;
         end
      end
      #1;
      check("rr.out_valid", 64'(rr_out_valid), 64'(m_valid[0]));
      check("rr.out_data",  64'(rr_out_data),  64'(m_data[0]));
      check("rr.out_chan",  64'(rr_out_chan),  64'(m_chan[0]));
      check("fp.out_valid", 64'(fp_out_valid), 64'(m_valid[1]));
      check("fp.out_data",  64'(fp_out_data),  64'(m_data[1]));
      check("fp.out_chan",  64'(fp_out_chan),  64'(m_chan[1]));
   endtask

   task automatic set_both(input logic [N-1:0] v, input logic rdy);
      s_valid[0]  = v;
      s_valid[1]  = v;
      s_oready[0] = rdy;
      s_oready[1] = rdy;
   endtask

   initial begin
      logic [W-1:0] held_data;

      // Power-on reset: outputs must be zero and in_ready low even while requests are present
      model_reset();
      for (int i = 0; i < N; i++) begin
         s_word[0][i] = '0;
         s_word[1][i] = '0;
      end
      reset_n = 1'b0;
      set_both(4'b1111, 1'b1);
      #2;
      check("reset.out_valid", 64'(rr_out_valid), 64'd0);
      check("reset.in_ready",  64'(rr_in_ready | fp_in_ready), 64'd0);
      set_both(4'b0000, 1'b1);
      #10 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Only channel 2 requests
      s_word[0][2] = 32'hDEADBEEF;
      s_word[1][2] = 32'hDEADBEEF;
      set_both(4'b0100, 1'b1);
      step();
      check("single.in_ready", 64'(last_ready[0]), 64'h4);
      check("single.data",     64'(rr_out_data),   64'hDEADBEEF);
      check("single.chan",     64'(rr_out_chan),   64'd2);

      // The pointer is now 3; with only channels 0 and 1 requesting, the search wraps to 0, then 1
      set_both(4'b0011, 1'b1);
      step();
      check("wrap.first",  64'(rr_out_chan), 64'd0);
      step();
      check("wrap.second", 64'(rr_out_chan), 64'd1);

      // Asynchronous reset in the middle of a cycle, while the output register holds a word
      check("pre_reset.valid", 64'(rr_out_valid), 64'd1);
      #3 reset_n = 1'b0;
      #1;
      check("midreset.out_valid", 64'(rr_out_valid | fp_out_valid), 64'd0);
      check("midreset.out_data",  64'(rr_out_data | fp_out_data),   64'd0);
      check("midreset.out_chan",  64'(rr_out_chan | fp_out_chan),   64'd0);
      check("midreset.in_ready",  64'(rr_in_ready | fp_in_ready),   64'd0);
      model_reset();
      set_both(4'b0000, 1'b1);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Fairness: all channels request continuously, and the pointer starts at 0
      for (int i = 0; i < N; i++) begin
         s_word[0][i] = 32'h1000_0000 + i;
         s_word[1][i] = 32'h1000_0000 + i;
      end
      set_both(4'b1111, 1'b1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("fair.chan", 64'(rr_out_chan), 64'(k % N));
         check("fair.data", 64'(rr_out_data), 64'(32'h1000_0000 + (k % N)));
      end

      // Backpressure: the held word stays put and nothing is accepted
      held_data = rr_out_data;
      set_both(4'b1111, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall.in_ready", 64'(last_ready[0]), 64'd0);
         check("stall.chan",     64'(rr_out_chan),   64'd1);
         check("stall.data",     64'(rr_out_data),   64'(held_data));
      end
      set_both(4'b1111, 1'b1);
      step();
      check("release.in_ready", 64'(last_ready[0]), 64'h4);
      check("release.chan",     64'(rr_out_chan),   64'd2);

      // Fixed priority: channel 1 always beats channel 3
      set_both(4'b1010, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step();
         check("fixed.chan", 64'(fp_out_chan), 64'd1);
      end
      set_both(4'b1000, 1'b1);
      step();
      check("fixed.drop", 64'(fp_out_chan), 64'd3);

      // Random traffic: a producer keeps its word until it is accepted
      set_both(4'b0000, 1'b1);
      step();
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 2; d++) begin
            s_oready[d] = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
               if (!(s_valid[d][i[CWB-1:0]] && !last_acc[d][i[CWB-1:0]])) begin
                  s_valid[d][i[CWB-1:0]] = 1'($urandom_range(0, 1));
                  s_word[d][i] = $urandom;
               end
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
